// File: rtl/pulse_swallow_div.sv
// Pulse-swallow integer-N clock divider: N = PRE_M*P + S.
// An M/M+1 prescaler is clocked by a P (program) counter and an S (swallow)
// counter. New P/S values are double-buffered and only take effect at a
// period boundary.
// Optional build macro PULSE_SWALLOW_DIV_DUTY50_EN: when defined, div_clk is a
// ~50% duty divided clock derived from a per-period cycle counter; otherwise
// div_clk is a delayed, inverted copy of the modulus-control signal.
module pulse_swallow_div #(
  parameter int unsigned P_WIDTH = 5,
  parameter int unsigned S_WIDTH = 3,
  parameter int unsigned PRE_M   = 8,
  parameter int unsigned P_INIT  = 5,
  parameter int unsigned S_INIT  = 3,
  parameter int unsigned N_WIDTH = P_WIDTH + 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [P_WIDTH-1:0] cfg_p,
  input  logic [S_WIDTH-1:0] cfg_s,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               div_pulse,
  output logic               div_clk,
  output logic [N_WIDTH-1:0] ratio
);

  // Prescaler counts up to PRE_M inclusive when swallowing.
  localparam int unsigned PreW = $clog2(PRE_M + 1);

  logic [PreW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [P_WIDTH-1:0] p_cnt_q, p_cnt_d;
  logic [S_WIDTH-1:0] s_cnt_q, s_cnt_d;
  logic [P_WIDTH-1:0] act_p_q, act_p_d;
  logic [S_WIDTH-1:0] act_s_q, act_s_d;
  logic               pend_v_q, pend_v_d;
  logic [P_WIDTH-1:0] pend_p_q, pend_p_d;
  logic [S_WIDTH-1:0] pend_s_q, pend_s_d;
  logic               cfg_err_q, cfg_err_d;
  logic               div_clk_q, div_clk_d;
  logic [N_WIDTH-1:0] ratio_q, ratio_d;

  logic               mc;
  logic [PreW-1:0]    pre_last;
  logic               pre_wrap;
  logic               period_end;
  logic               load_pend;
  logic [P_WIDTH-1:0] new_p;
  logic [S_WIDTH-1:0] new_s;
  logic               accept;
  logic               legal;

`ifdef PULSE_SWALLOW_DIV_DUTY50_EN
  logic [N_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [N_WIDTH-1:0] half_n;
`endif

  // Modulus control, prescaler wrap and period-end decode from current state only.
  always_comb begin
    mc         = (s_cnt_q != '0);
    pre_last   = mc ? PreW'(PRE_M) : PreW'(PRE_M - 1);
    pre_wrap   = (pre_cnt_q == pre_last);
    period_end = pre_wrap && (p_cnt_q == '0);
    load_pend  = period_end && pend_v_q;
    new_p      = load_pend ? pend_p_q : act_p_q;
    new_s      = load_pend ? pend_s_q : act_s_q;
    accept     = cfg_valid && !pend_v_q;
    legal      = (cfg_p != '0) && (N_WIDTH'(cfg_s) <= N_WIDTH'(cfg_p));
  end

  // Next-state: counters, config double-buffer, ratio and div_clk.
  always_comb begin
    pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + 1'b1;
    p_cnt_d   = p_cnt_q;
    s_cnt_d   = s_cnt_q;
    act_p_d   = act_p_q;
    act_s_d   = act_s_q;
    pend_v_d  = pend_v_q;
    pend_p_d  = pend_p_q;
    pend_s_d  = pend_s_q;
    ratio_d   = ratio_q;
    cfg_err_d = accept && !legal;

    if (pre_wrap) begin
      if (s_cnt_q != '0) s_cnt_d = s_cnt_q - 1'b1;
      if (p_cnt_q != '0) p_cnt_d = p_cnt_q - 1'b1;
      if (period_end) begin
        // Reload from the config that governs the next period.
        p_cnt_d = new_p - 1'b1;
        s_cnt_d = new_s;
        ratio_d = N_WIDTH'(PRE_M) * N_WIDTH'(new_p) + N_WIDTH'(new_s);
      end
    end

    if (load_pend) begin
      act_p_d  = pend_p_q;
      act_s_d  = pend_s_q;
      pend_v_d = 1'b0;
    end

    // Accept only happens with an empty slot, so it never collides with load_pend.
    if (accept && legal) begin
      pend_v_d = 1'b1;
      pend_p_d = cfg_p;
      pend_s_d = cfg_s;
    end

`ifdef PULSE_SWALLOW_DIV_DUTY50_EN
    per_cnt_d = period_end ? '0 : per_cnt_q + 1'b1;
    // ceil(N/2) without risking overflow of N+1.
    half_n    = (ratio_d >> 1) + N_WIDTH'(ratio_d[0]);
    div_clk_d = (per_cnt_d < half_n);
`else
    div_clk_d = ~mc;
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      p_cnt_q   <= P_WIDTH'(P_INIT - 1);
      s_cnt_q   <= S_WIDTH'(S_INIT);
      act_p_q   <= P_WIDTH'(P_INIT);
      act_s_q   <= S_WIDTH'(S_INIT);
      pend_v_q  <= 1'b0;
      pend_p_q  <= '0;
      pend_s_q  <= '0;
      cfg_err_q <= 1'b0;
      div_clk_q <= 1'b0;
      ratio_q   <= N_WIDTH'(PRE_M * P_INIT + S_INIT);
`ifdef PULSE_SWALLOW_DIV_DUTY50_EN
      per_cnt_q <= '0;
`endif
    end else begin
      pre_cnt_q <= pre_cnt_d;
      p_cnt_q   <= p_cnt_d;
      s_cnt_q   <= s_cnt_d;
      act_p_q   <= act_p_d;
      act_s_q   <= act_s_d;
      pend_v_q  <= pend_v_d;
      pend_p_q  <= pend_p_d;
      pend_s_q  <= pend_s_d;
      cfg_err_q <= cfg_err_d;
      div_clk_q <= div_clk_d;
      ratio_q   <= ratio_d;
`ifdef PULSE_SWALLOW_DIV_DUTY50_EN
      per_cnt_q <= per_cnt_d;
`endif
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    cfg_ready = ~pend_v_q;
    cfg_err   = cfg_err_q;
    div_pulse = period_end;
    div_clk   = div_clk_q;
    ratio     = ratio_q;
  end

endmodule

// File: tb/tb_pulse_swallow_div.sv
// Bench for pulse_swallow_div: behavioural model tracks position within the
// current period and the double-buffered config; expected pulses and errors
// go into queues that a separate monitor drains when the DUT shows them.
module tb_pulse_swallow_div;

  localparam int unsigned M = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [4:0]  cfg_p = '0;
  logic [2:0]  cfg_s = '0;
  logic        cfg_ready, cfg_err, div_pulse, div_clk;
  logic [12:0] ratio;

  always #5 clk = ~clk;

  pulse_swallow_div dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_p     (cfg_p),
    .cfg_s     (cfg_s),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_pulse (div_pulse),
    .div_clk   (div_clk),
    .ratio     (ratio)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned n;
  } pulse_t;

  pulse_t      pq[$];
  int unsigned eq[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  // Model state
  int unsigned m_p, m_s, m_pp, m_ps, m_k;
  bit          m_pv, m_err, m_known = 1'b0, m_rst_prev, m_mc_prev;

  // Stimulus state
  bit          rst_r = 1'b1;
  bit          off_v = 1'b0;
  int unsigned off_p = 0, off_s = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int unsigned n_of(input int unsigned p, input int unsigned s);
    return M * p + s;
  endfunction

  // One clock cycle: check this cycle's outputs, drive inputs, advance the model.
  task automatic step();
    int unsigned n;
    bit acc, legal, mc, new_err, exp_dclk;
    @(negedge clk);
    cyc++;
    if (m_known) begin
      n = n_of(m_p, m_s);
      chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_pv});
      chk("ratio", {19'b0, ratio}, n);
`ifdef PULSE_SWALLOW_DIV_DUTY50_EN
      exp_dclk = m_rst_prev ? 1'b0 : (m_k < (n + 1) / 2);
`else
      exp_dclk = m_rst_prev ? 1'b0 : !m_mc_prev;
`endif
      chk("div_clk", {31'b0, div_clk}, {31'b0, exp_dclk});
      if (m_k == n - 1) pq.push_back('{cyc: cyc, n: n});
      if (m_err) eq.push_back(cyc);
    end
    rst       = rst_r;
    cfg_valid = off_v;
    cfg_p     = off_p[4:0];
    cfg_s     = off_s[2:0];
    if (rst_r) begin
      m_p = 5; m_s = 3; m_pv = 1'b0; m_k = 0; m_err = 1'b0;
      m_known = 1'b1; m_rst_prev = 1'b1; m_mc_prev = 1'b0;
    end else if (m_known) begin
      n       = n_of(m_p, m_s);
      acc     = off_v && !m_pv;
      legal   = (off_p >= 1) && (off_s <= off_p);
      mc      = (m_k < m_s * (M + 1));
      new_err = acc && !legal;
      if (m_k == n - 1) begin
        if (m_pv) begin
          m_p = m_pp; m_s = m_ps; m_pv = 1'b0;
        end
        m_k = 0;
      end else begin
        m_k++;
      end
      if (acc && legal) begin
        m_pv = 1'b1; m_pp = off_p; m_ps = off_s;
      end
      if (acc) off_v = 1'b0;
      m_err      = new_err;
      m_mc_prev  = mc;
      m_rst_prev = 1'b0;
    end
  endtask

  // Offer a config and hold it until the handshake completes.
  task automatic send(input int unsigned p, input int unsigned s);
    int unsigned i;
    off_p = p; off_s = s; off_v = 1'b1;
    for (i = 0; i < 600 && off_v; i++) step();
    if (off_v) begin
      chk("send_timeout", 32'd1, 32'd0);
      off_v = 1'b0;
    end
  endtask

  // Advance until the upcoming cycle is the last of its period.
  task automatic wait_end();
    for (int i = 0; i < 600 && !(m_k == n_of(m_p, m_s) - 1); i++) step();
    if (!(m_k == n_of(m_p, m_s) - 1)) chk("wait_end_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse or error.
  always begin
    @(negedge clk);
    #2;
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL missed_pulse got=none expected_cyc=%0d", pq[0].cyc);
      void'(pq.pop_front());
    end
    if (div_pulse === 1'b1) begin
      if (pq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pulse got_cyc=%0d expected=none", cyc);
      end else begin
        chk("pulse_cyc", cyc, pq[0].cyc);
        chk("pulse_ratio", {19'b0, ratio}, pq[0].n);
        void'(pq.pop_front());
      end
    end
    while (eq.size() > 0 && eq[0] < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL missed_err got=none expected_cyc=%0d", eq[0]);
      void'(eq.pop_front());
    end
    if (cfg_err === 1'b1) begin
      if (eq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_err got_cyc=%0d expected=none", cyc);
      end else begin
        chk("err_cyc", cyc, eq[0]);
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    // Reset defaults: 43-cycle periods.
    rst_r = 1'b1;
    repeat (3) step();
    rst_r = 1'b0;
    repeat (43 * 3) step();

    // Illegal configs: one-cycle err, nothing stored.
    repeat (7) step();
    send(4, 5);
    repeat (5) step();
    send(0, 0);
    repeat (43 * 2) step();

    // Mid-period accept: current period stays 43, then 80.
    repeat (11) step();
    send(10, 0);
    repeat (43 + 80 * 2) step();

    // Accept on the exact period-end cycle: takes effect one boundary later.
    wait_end();
    off_p = 6; off_s = 6; off_v = 1'b1;
    step();
    repeat (80 + 54 * 2) step();

    // Reset mid-period with a pending config: pending discarded.
    repeat (9) step();
    send(2, 1);
    repeat (5) step();
    rst_r = 1'b1;
    repeat (2) step();
    rst_r = 1'b0;
    repeat (43 * 2 + 3) step();

    // Back-to-back: second offer held until the slot frees.
    send(2, 1);
    send(31, 7);
    repeat (17 + 255 * 2) step();

    // Randomized configs, including illegal ones and occasional resets.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 150)) step();
      if (!off_v) begin
        off_p = $urandom_range(0, 31);
        off_s = $urandom_range(0, 7);
        off_v = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        rst_r = 1'b1;
        step();
        rst_r = 1'b0;
      end
    end
    off_v = 1'b0;
    repeat (300) step();
    #4;
    chk("pulse_queue_empty", pq.size(), 32'd0);
    chk("err_queue_empty", eq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
